mesh_perf_monitor: RTL and testbench
====================================

# mesh_perf_monitor

Synthesizable per-node performance and liveness monitor for the ROWS×COLS neuromorphic mesh. It samples each node's PC, instruction-memory busywait, data-memory busywait and load-use hazard signal every cycle. It keeps saturating per-node event counters and flags nodes whose PC has stopped advancing. Counters are read out one at a time over a request/acknowledge port. The block sits beside the `mesh` instance and replaces console monitoring with hardware counters readable by a host or bench.

## Interface
Parameters:
- ROWS, 2, mesh rows
- COLS, 2, mesh columns
- PC_WIDTH, 32, width of each node PC
- CNT_WIDTH, 32, width of every event counter and of rd_data
- WDOG_CYCLES, 1024, PC-unchanged cycles before a node is flagged hung (≥2)
- Derived: N = ROWS*COLS; NIDX = max(1, clog2(N)); node index = row*COLS + col

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; clears all state
- enable  in  1  counting/watchdog enable
- clr  in  1  synchronous clear of all counters and hung flags
- pc_flat  in  N*PC_WIDTH  node i PC at bits [i*PC_WIDTH +: PC_WIDTH]
- imem_busy  in  N  instruction-memory busywait per node
- dmem_busy  in  N  data-memory busywait per node
- haz  in  N  load-use hazard per node
- rd_req  in  1  read request
- rd_node  in  NIDX  node to read
- rd_sel  in  2  0=active cycles, 1=imem stalls, 2=dmem stalls, 3=hazard cycles
- rd_ack  out  1  one-cycle pulse; rd_data valid
- rd_data  out  CNT_WIDTH  selected counter snapshot
- hung  out  N  sticky per-node hung flag
- any_hung  out  1  OR of hung

## Operation
- Counters: 4 per node, CNT_WIDTH each.
  - Counters saturate at all-ones and never wrap.
  - When enable=1 at an edge:
    - active increments.
    - imem increments if imem_busy[i].
    - dmem increments if dmem_busy[i].
    - hazard increments if haz[i].
  - When enable=0, all counters hold.
- clr=1 zeroes all counters, watchdog counters, hung flags and the last-PC registers. clr has priority over any increment on the same edge.
- Read FSM states:
  - IDLE: rd_req=1 latches the counter selected by rd_node/rd_sel into rd_data, then goes to ACK.
  - ACK: rd_ack=1 for one cycle, then returns to IDLE unconditionally. rd_req is ignored in ACK.
- rd_data holds its value until the next accepted read.
- rd_node ≥ N: the read completes normally with rd_data=0.
- A read with clr on the same edge returns the pre-clear value.

## Timing
- Reset values: rd_ack=0, rd_data=0, hung=0, any_hung=0, FSM=IDLE, all counters 0.
- Counter increments are visible to a read accepted on the following edge.
- Read latency: rd_req high at edge T gives rd_ack=1 and valid rd_data during cycle T+1. rd_ack drops at T+2.
- Back-to-back reads: at most one read every 2 cycles. rd_req held high gives an ack every other cycle.
- Snapshot semantics: rd_data equals the counter value before the update at edge T.
- any_hung is combinational from the hung registers, so it has no added latency.
- Reset asserted mid-read forces IDLE and rd_ack=0 immediately (asynchronous).

## Configuration
- MESH_MON_WATCHDOG_EN defined:
  - Each node keeps a last-PC register and a watchdog counter.
  - The watchdog counter counts cycles with enable=1 and PC equal to last-PC.
  - A PC change zeroes the counter.
  - When the counter reaches WDOG_CYCLES, hung[i] sets on that edge and stays set until clr or rst.
- MESH_MON_WATCHDOG_EN undefined: no watchdog logic; hung and any_hung are tied to 0.

## Test plan
- Reset then idle, no enable: read node 0 sel 0 -> rd_ack at T+1, rd_data=0. hung=0.
- enable=1 for 100 cycles with imem_busy[3]=1 for 10 of them -> node 3: sel 0=100, sel 1=10; node 0 sel 1=0.
- Preload near saturation (CNT_WIDTH=8), 300 enabled cycles -> sel 0 reads 255, no wrap.
- clr on same edge as enable and dmem_busy -> that read returns pre-clear value; next read returns 0.
- Watchdog (macro on, WDOG_CYCLES=16): node 1 PC frozen, others incrementing -> hung=4'b0010 after 16 enabled cycles, any_hung=1, sticky until clr. Macro off -> hung stays 0.
- rd_node=7 with N=4 -> rd_ack pulses, rd_data=0. rd_req held high -> acks every second cycle.

Source files
------------

// File: rtl/mesh_perf_monitor.sv
// Per-node event counters and PC watchdog for the ROWS x COLS mesh, read one counter at a time.
// Optional PC-stall watchdog is built only when MESH_MON_WATCHDOG_EN is defined.
module mesh_perf_monitor #(
  parameter int ROWS        = 2,
  parameter int COLS        = 2,
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int WDOG_CYCLES = 1024,
  localparam int N          = ROWS * COLS,
  localparam int NIDX       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr,
  input  logic [N*PC_WIDTH-1:0] pc_flat,
  input  logic [N-1:0]          imem_busy,
  input  logic [N-1:0]          dmem_busy,
  input  logic [N-1:0]          haz,
  input  logic                  rd_req,
  input  logic [NIDX-1:0]       rd_node,
  input  logic [1:0]            rd_sel,
  output logic                  rd_ack,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [N-1:0]          hung,
  output logic                  any_hung
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [CNT_WIDTH-1:0]       r_rd_data;
  logic [CNT_WIDTH-1:0]       w_sel_val;
  logic [N*4*CNT_WIDTH-1:0]   w_cnt_flat;
  logic [N-1:0]               w_hung;

  // Counter k of node i lives at slot i*4+k: 0=active, 1=imem, 2=dmem, 3=hazard.
  for (genvar gi = 0; gi < N; gi++) begin : g_node
    logic [3:0] w_inc;
    assign w_inc = {haz[gi], dmem_busy[gi], imem_busy[gi], 1'b1};

    for (genvar gk = 0; gk < 4; gk++) begin : g_cnt
      logic [CNT_WIDTH-1:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (enable && w_inc[gk] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_cnt_flat[(gi*4+gk)*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end

`ifdef MESH_MON_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [PC_WIDTH-1:0] r_last_pc;
    logic [WW-1:0]       r_wdog;
    logic                r_hung;
    logic [PC_WIDTH-1:0] w_pc;
    assign w_pc = pc_flat[gi*PC_WIDTH +: PC_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_last_pc <= '0;
        r_wdog    <= '0;
        r_hung    <= 1'b0;
      end else if (clr) begin
        r_last_pc <= '0;
        r_wdog    <= '0;
        r_hung    <= 1'b0;
      end else if (enable) begin
        r_last_pc <= w_pc;
        if (w_pc != r_last_pc) begin
          r_wdog <= '0;
        end else if (r_wdog != WW'(WDOG_CYCLES)) begin
          r_wdog <= r_wdog + 1'b1;
          if (r_wdog == WW'(WDOG_CYCLES - 1)) r_hung <= 1'b1;
        end
      end
    end
    assign w_hung[gi] = r_hung;
`else
    assign w_hung[gi] = 1'b0;
`endif
  end

  always_comb begin
    w_sel_val = '0;
    if (int'(rd_node) < N) begin
      w_sel_val = w_cnt_flat[(int'(rd_node)*4 + int'(rd_sel))*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && rd_req) r_rd_data <= w_sel_val;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (rd_req) w_state_next = S_ACK;
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign rd_ack   = (r_state == S_ACK);
  assign rd_data  = r_rd_data;
  assign hung     = w_hung;
  assign any_hung = |w_hung;

endmodule

// File: tb/tb_mesh_perf_monitor.sv
// Directed bench for mesh_perf_monitor on a 2x3 mesh with 8-bit counters and a 16-cycle watchdog.
module tb_mesh_perf_monitor;
  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int N    = ROWS * COLS;
  localparam int PCW  = 32;
  localparam int CW   = 8;
  localparam int WD   = 16;
  localparam int NIDX = 3;

`ifdef MESH_MON_WATCHDOG_EN
  localparam logic [N-1:0] HUNG_EXP = 6'b000010;
`else
  localparam logic [N-1:0] HUNG_EXP = 6'b000000;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            clr;
  logic [N*PCW-1:0] pc_flat;
  logic [N-1:0]    imem_busy;
  logic [N-1:0]    dmem_busy;
  logic [N-1:0]    haz;
  logic            rd_req;
  logic [NIDX-1:0] rd_node;
  logic [1:0]      rd_sel;
  logic            rd_ack;
  logic [CW-1:0]   rd_data;
  logic [N-1:0]    hung;
  logic            any_hung;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pc_step  = 0;
  logic freeze1  = 1'b0;

  mesh_perf_monitor #(
    .ROWS(ROWS), .COLS(COLS), .PC_WIDTH(PCW), .CNT_WIDTH(CW), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr(clr), .pc_flat(pc_flat),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .haz(haz),
    .rd_req(rd_req), .rd_node(rd_node), .rd_sel(rd_sel),
    .rd_ack(rd_ack), .rd_data(rd_data), .hung(hung), .any_hung(any_hung)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every node's PC moves each enabled cycle unless node 1 is frozen at 0.
  task automatic set_pcs();
    for (int i = 0; i < N; i++) begin
      pc_flat[i*PCW +: PCW] = (i == 1 && freeze1) ? 32'h0 : 32'(pc_step*4 + i*32'h1000 + 4);
    end
  endtask

  task automatic run_en(input int n, input logic [N-1:0] im, input logic [N-1:0] dm,
                        input logic [N-1:0] hz);
    for (int c = 0; c < n; c++) begin
      set_pcs();
      enable    = 1'b1;
      imem_busy = im;
      dmem_busy = dm;
      haz       = hz;
      tick();
      pc_step++;
    end
    enable    = 1'b0;
    imem_busy = '0;
    dmem_busy = '0;
    haz       = '0;
  endtask

  task automatic do_read(input int node, input int sel, input string tag, input logic [CW-1:0] exp);
    rd_req  = 1'b1;
    rd_node = NIDX'(node);
    rd_sel  = 2'(sel);
    tick();
    rd_req = 1'b0;
    check({tag, " ack"}, rd_ack, 1);
    check(tag, rd_data, exp);
    tick();
    check({tag, " ack drop"}, rd_ack, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clr = 1'b0; pc_flat = '0;
    imem_busy = '0; dmem_busy = '0; haz = '0;
    rd_req = 1'b0; rd_node = '0; rd_sel = '0;
    tick(); tick();
    check("reset rd_ack", rd_ack, 0);
    check("reset rd_data", rd_data, 0);
    check("reset hung", hung, 0);
    check("reset any_hung", any_hung, 0);
    rst = 1'b0;
    tick(); tick();

    do_read(0, 0, "idle n0 active", 8'd0);
    check("idle hung", hung, 0);

    // 100 enabled cycles with per-node busy bursts of known length
    run_en(10, 6'b001000, 6'b000000, 6'b000000);
    run_en(5,  6'b000000, 6'b000100, 6'b000000);
    run_en(7,  6'b000000, 6'b000000, 6'b000010);
    run_en(78, 6'b000000, 6'b000000, 6'b000000);
    do_read(3, 0, "n3 active", 8'd100);
    do_read(3, 1, "n3 imem", 8'd10);
    check("rd_data held", rd_data, 10);
    do_read(0, 1, "n0 imem", 8'd0);
    do_read(2, 2, "n2 dmem", 8'd5);
    do_read(1, 3, "n1 haz", 8'd7);
    do_read(5, 0, "n5 active", 8'd100);
    check("no hang while PCs move", hung, 0);

    // 300 more cycles push active and node 0 imem past 255
    run_en(300, 6'b000001, 6'b000000, 6'b000000);
    do_read(0, 0, "n0 active sat", 8'd255);
    do_read(0, 1, "n0 imem sat", 8'd255);
    do_read(3, 1, "n3 imem kept", 8'd10);

    // clr, enable, dmem_busy and a read all on one edge
    set_pcs();
    enable = 1'b1; dmem_busy = 6'b000100; clr = 1'b1;
    rd_req = 1'b1; rd_node = 3'd2; rd_sel = 2'd2;
    tick();
    enable = 1'b0; dmem_busy = '0; clr = 1'b0; rd_req = 1'b0;
    check("clr-edge ack", rd_ack, 1);
    check("clr-edge pre-clear", rd_data, 5);
    tick();
    do_read(2, 2, "n2 dmem cleared", 8'd0);
    do_read(0, 0, "n0 active cleared", 8'd0);

    // out-of-range node reads
    run_en(5, 6'b000000, 6'b000000, 6'b000000);
    do_read(0, 0, "n0 active 5", 8'd5);
    do_read(7, 0, "node7 oor", 8'd0);
    do_read(0, 0, "n0 active 5 again", 8'd5);
    do_read(6, 1, "node6 oor", 8'd0);

    // rd_req held high: ack on alternate cycles
    rd_req = 1'b1; rd_node = 3'd0; rd_sel = 2'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("held req ack cyc%0d", i), rd_ack, (i % 2 == 0) ? 1 : 0);
    end
    rd_req = 1'b0;
    tick();
    check("held req data", rd_data, 5);

    // watchdog: node 1 frozen at PC 0 from a clean clear
    clr = 1'b1; tick(); clr = 1'b0;
    freeze1 = 1'b1;
    run_en(WD - 1, '0, '0, '0);
    check("wdog before limit", hung, 0);
    check("wdog any before limit", any_hung, 0);
    run_en(1, '0, '0, '0);
    check("wdog at limit", hung, HUNG_EXP);
    check("wdog any at limit", any_hung, |HUNG_EXP);
    tick(); tick();
    freeze1 = 1'b0;
    run_en(3, '0, '0, '0);
    check("wdog sticky", hung, HUNG_EXP);
    clr = 1'b1; tick(); clr = 1'b0;
    check("wdog cleared", hung, 0);
    check("wdog any cleared", any_hung, 0);

    // asynchronous reset in the middle of a read
    rd_req = 1'b1; rd_node = 3'd0; rd_sel = 2'd0;
    tick();
    rd_req = 1'b0;
    check("pre-reset ack", rd_ack, 1);
    #1 rst = 1'b1;
    #1;
    check("async reset ack", rd_ack, 0);
    check("async reset data", rd_data, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
